ac_store_unit: RTL

Write-back path for the 16-bit accumulator. The control unit issues a store (address plus current accumulator value). The block queues it in a small FIFO and drains each entry to data memory over a req/ack handshake, with a timeout guard. This lets the CPU keep executing while stores are committed.

---
 rtl/ac_store_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ac_store_unit.sv
// Accumulator store queue: buffers {addr, data} stores and commits them to data memory over req/ack.
// Latency: a store into an empty queue raises mem_req one cycle after acceptance; the entry retires on ack or timeout.
// Backpressure: st_ready drops while the queue is full (optional STORE_MERGE_EN lets a same-address store merge even when full).
module ac_store_unit #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 12,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] ac_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              err,
   input  logic              err_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [0:0]        state;
   logic [TW-1:0]     wait_cnt;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              to_hit;
   logic [DATA_W-1:0] head_wdata;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

`ifdef STORE_MERGE_EN
   logic [PW-1:0] last_ptr;
   logic          merge_hit;
   logic          merge;

   // Newest entry; it equals the head only when exactly one entry is queued.
   assign last_ptr = wr_ptr - 1'b1;

   // A store to the newest entry's address folds into it, unless that entry is already on the bus.
   assign merge_hit = !empty && (st_addr == addr_mem[last_ptr]) &&
                      !((last_ptr == rd_ptr) && (state == ISSUE));
   assign st_ready  = !full || merge_hit;
   assign merge     = st_valid && merge_hit;
   assign push      = st_valid && st_ready && !merge_hit;

   // When the head is issued in the same cycle it is merged into, forward the new data.
   assign head_wdata = (merge && (last_ptr == rd_ptr)) ? ac_in : data_mem[rd_ptr];
`else
   assign st_ready   = !full;
   assign push       = st_valid && st_ready;
   assign head_wdata = data_mem[rd_ptr];
`endif

   // Head retires on ack or when the wait budget runs out.
   assign to_hit = (state == ISSUE) && !mem_ack && (wait_cnt == TO_LAST);
   assign pop    = (state == ISSUE) && (mem_ack || to_hit);

   assign mem_we = mem_req;
   assign busy   = (count != '0) || (state != IDLE);

   // Entry storage: allocate at the tail, or overwrite the newest entry on a merge.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= st_addr;
         data_mem[wr_ptr] <= ac_in;
      end
`ifdef STORE_MERGE_EN
      else if (merge) begin
         data_mem[last_ptr] <= ac_in;
      end
`endif
   end

   // Queue bookkeeping: pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Memory-side sequencer: latch the head onto the bus, then wait for ack or timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wait_cnt  <= '0;
      end else if (state == IDLE) begin
         if (!empty) begin
            mem_addr  <= addr_mem[rd_ptr];
            mem_wdata <= head_wdata;
            mem_req   <= 1'b1;
            wait_cnt  <= '0;
            state     <= ISSUE;
         end
      end else begin
         if (mem_ack || to_hit) begin
            mem_req <= 1'b0;
            state   <= IDLE;
         end else begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   // Sticky timeout flag; a new timeout outranks a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (to_hit) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

endmodule
